// File: rtl/imem_port_arbiter.sv
// Two-requester arbiter (IF fetch, D load/store) in front of a single-port word memory.
// Optional build macro ARB_PERF_CNT_EN adds the conflict_cnt performance counter.
module imem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]       conflict_cnt
`endif
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state_reg, state_next;
  logic                gnt_d_reg;
  logic [3:0]          starve_reg, starve_next;
  logic                mem_ce_reg, mem_we_reg;
  logic [ADDR_W-1:0]   mem_addr_reg;
  logic [DATA_W-1:0]   mem_wdata_reg;
  logic [DATA_W-1:0]   if_rdata_reg, d_rdata_reg;
  logic                if_done_reg, d_done_reg;
  logic                arb_phase, if_elig, d_elig, pick_if, pick_d;

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next  = state_reg;
    starve_next = starve_reg;
    arb_phase   = (state_reg == IDLE) || (state_reg == RESP);
    // the port completing in RESP must not be granted again off its stale request
    if_elig     = arb_phase && if_req && !((state_reg == RESP) && !gnt_d_reg);
    d_elig      = arb_phase && d_req  && !((state_reg == RESP) &&  gnt_d_reg);
    pick_if     = if_elig && (!d_elig || (starve_reg == STARVE_LIM));
    pick_d      = d_elig && !pick_if;
    if (pick_if)
      starve_next = 4'd0;
    else if (if_elig && (starve_reg < STARVE_LIM))
      starve_next = starve_reg + 4'd1;
    case (state_reg)
      ACCESS:  state_next = RESP;
      default: state_next = (pick_if || pick_d) ? ACCESS : IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt_d_reg     <= 1'b0;
      starve_reg    <= 4'd0;
      mem_ce_reg    <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      if_rdata_reg  <= '0;
      d_rdata_reg   <= '0;
      if_done_reg   <= 1'b0;
      d_done_reg    <= 1'b0;
    end else begin
      starve_reg  <= starve_next;
      if_done_reg <= (state_reg == ACCESS) && !gnt_d_reg;
      d_done_reg  <= (state_reg == ACCESS) &&  gnt_d_reg;
      if (pick_if || pick_d) begin
        gnt_d_reg     <= pick_d;
        mem_ce_reg    <= 1'b1;
        mem_we_reg    <= pick_d && d_we;
        mem_addr_reg  <= pick_d ? d_addr : if_addr;
        mem_wdata_reg <= d_wdata;
      end else begin
        mem_ce_reg <= 1'b0;
        mem_we_reg <= 1'b0;
      end
      if (state_reg == ACCESS) begin
        if (!gnt_d_reg)
          if_rdata_reg <= mem_rdata;
        else if (!mem_we_reg)
          d_rdata_reg <= mem_rdata;
      end
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [31:0] conflict_cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n)
      conflict_cnt_reg <= 32'd0;
    else if (if_elig && d_elig)
      conflict_cnt_reg <= conflict_cnt_reg + 32'd1;
  end

  assign conflict_cnt = conflict_cnt_reg;
`endif

  assign mem_ce    = mem_ce_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign if_rdata  = if_rdata_reg;
  assign d_rdata   = d_rdata_reg;
  assign if_done   = if_done_reg;
  assign d_done    = d_done_reg;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: timestamp-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_imem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SMAX = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic [DW-1:0] if_rdata;
  logic          if_done;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] d_rdata;
  logic          d_done;
  logic          mem_ce, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
`ifdef ARB_PERF_CNT_EN
  logic [31:0]   conflict_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  imem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef ARB_PERF_CNT_EN
    , .conflict_cnt(conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  // memory instance and the model's private copy of its contents
  logic [DW-1:0] mem [64];
  logic [DW-1:0] ref_mem [64];
  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i]     = 32'h1000_0000 + 32'(i) * 32'h0001_0101;
      ref_mem[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0101;
    end
    mem[2]     = 32'h8f990068;
    ref_mem[2] = 32'h8f990068;
  end
  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) if (mem_ce && mem_we) mem[mem_addr[7:2]] <= mem_wdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: a grant issued while inputs are present in cycle g makes
  // cycle g+1 the memory access and cycle g+2 the done cycle; the next grant may
  // be issued in cycle g+2 but not for the port finishing there.
  int          cyc = 0;
  int          last_g = -100;
  bit          mvalid = 0;
  bit          g_d = 0, g_we = 0;
  logic [31:0] g_data = '0;
  int          starve = 0;
  logic        e_ce = 0, e_we = 0, e_ifd = 0, e_dd = 0;
  logic [31:0] e_addr = '0, e_wd = '0, e_ird = '0, e_drd = '0, e_cnt = '0;

  always @(negedge clk) begin
    bit ie, de, win_if, win_d;
    logic [31:0] a;
    cyc++;
    if (mvalid) begin
      chk("mem_ce", 32'(mem_ce), 32'(e_ce));
      chk("mem_we", 32'(mem_we), 32'(e_we));
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_wdata", mem_wdata, e_wd);
      chk("if_done", 32'(if_done), 32'(e_ifd));
      chk("d_done", 32'(d_done), 32'(e_dd));
      chk("if_rdata", if_rdata, e_ird);
      chk("d_rdata", d_rdata, e_drd);
`ifdef ARB_PERF_CNT_EN
      chk("conflict_cnt", conflict_cnt, e_cnt);
`endif
    end
    if (!rst_n) begin
      mvalid = 1; last_g = -100; starve = 0;
      e_ce = 0; e_we = 0; e_ifd = 0; e_dd = 0;
      e_addr = '0; e_wd = '0; e_ird = '0; e_drd = '0; e_cnt = '0;
    end else begin
      e_ce = 0; e_we = 0; e_ifd = 0; e_dd = 0;
      if (cyc == last_g + 1) begin
        if (g_d) begin
          e_dd = 1;
          if (!g_we) e_drd = g_data;
        end else begin
          e_ifd = 1;
          e_ird = g_data;
        end
      end
      if (cyc >= last_g + 2) begin
        ie = if_req && !((cyc == last_g + 2) && !g_d);
        de = d_req  && !((cyc == last_g + 2) &&  g_d);
        if (ie && de) e_cnt = e_cnt + 32'd1;
        win_if = ie && (!de || starve == SMAX);
        win_d  = de && !win_if;
        if (win_if) starve = 0;
        else if (ie && starve < SMAX) starve++;
        if (win_if || win_d) begin
          last_g = cyc;
          g_d    = win_d;
          g_we   = win_d && d_we;
          a      = win_d ? d_addr : if_addr;
          g_data = ref_mem[a[7:2]];
          if (g_we) ref_mem[a[7:2]] = d_wdata;
          e_ce = 1; e_we = g_we; e_addr = a; e_wd = d_wdata;
        end
      end
    end
  end

  // returns the number of falling edges seen up to and including the done pulse
  task automatic wait_done(input bit want_d, input int max, output int n);
    bit seen = 0;
    n = 0;
    while (!seen && n < max) begin
      @(negedge clk);
      n++;
      seen = want_d ? d_done : if_done;
    end
    if (!seen) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout waiting for %s_done after %0d cycles", want_d ? "d" : "if", max);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    int n, dones;
    repeat (3) step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset mem_ce", 32'(mem_ce), 32'd0);
    chk("reset if_rdata", if_rdata, 32'd0);

    // IF alone
    step();
    if_req = 1; if_addr = 32'h8;
    @(negedge clk);
    @(negedge clk);
    chk("if access mem_ce", 32'(mem_ce), 32'd1);
    chk("if access mem_addr", mem_addr, 32'h8);
    @(negedge clk);
    chk("if alone if_done", 32'(if_done), 32'd1);
    chk("if alone if_rdata", if_rdata, 32'h8f990068);
    step();
    if_req = 0;

    // D write then read at the same address
    step();
    d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF;
    wait_done(1, 8, n);
    chk("d write latency", 32'(n), 32'd3);
    chk("d write keeps d_rdata", d_rdata, 32'd0);
    step();
    d_we = 0;
    wait_done(1, 8, n);
    chk("d read d_rdata", d_rdata, 32'hDEADBEEF);
    step();
    d_req = 0;

    // simultaneous requests: D first, IF two cycles later
    step();
    if_req = 1; if_addr = 32'h8; d_req = 1; d_we = 0; d_addr = 32'h40;
    wait_done(1, 8, n);
    chk("conflict d first", 32'(n), 32'd3);
    chk("conflict if not yet", 32'(if_done), 32'd0);
    step();
    d_req = 0;
    wait_done(0, 8, n);
    chk("conflict if after d", 32'(n), 32'd2);
    chk("conflict if_rdata", if_rdata, 32'h8f990068);
`ifdef ARB_PERF_CNT_EN
    chk("conflict_cnt", conflict_cnt, 32'd1);
`endif
    step();
    if_req = 0;

    // starvation: IF loses four conflicts (withdrawing in between), wins the fifth
    for (int k = 0; k < 4; k++) begin
      step();
      if_req = 1; d_req = 1; d_we = 0; d_addr = 32'h44;
      step();
      if_req = 0;
      wait_done(1, 8, n);
      chk("starve d wins", 32'(n), 32'd2);
      step();
      d_req = 0;
    end
    step();
    if_req = 1; d_req = 1;
    wait_done(0, 8, n);
    chk("starve if wins 5th", 32'(n), 32'd3);
    chk("starve d waits", 32'(d_done), 32'd0);
    step();
    if_req = 0;
    wait_done(1, 8, n);
    chk("starve d after if", 32'(n), 32'd2);
    step();
    d_req = 0;

    // reset in the middle of an access
    step();
    if_req = 1; if_addr = 32'h10;
    step();
    rst_n = 0; if_req = 0;
    @(posedge clk);
    @(negedge clk);
    chk("midreset mem_ce", 32'(mem_ce), 32'd0);
    chk("midreset d_rdata", d_rdata, 32'd0);
    chk("midreset if_rdata", if_rdata, 32'd0);
    step();
    rst_n = 1;
    dones = 0;
    repeat (5) begin
      @(negedge clk);
      dones += int'(if_done) + int'(d_done);
    end
    chk("midreset no done", 32'(dones), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
